// File: rtl/uart_rx_deserializer_if.sv
// Receive-byte handshake between the UART deserializer and its consumer.
// The deserializer drives data/valid as master; the consumer answers with ready.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronized line, start/data/stop FSM and a FWFT byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   rx_in,
  uart_rx_deserializer_if.master rx_if,
  output logic                   frame_err,
  output logic                   overrun,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   busy
);
  localparam int CW   = 16;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int IW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Asynchronous assert, release re-timed to PCLK.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic sync1_q, sync2_q, rx_s;

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 push_q, push_d;
  logic                 bit_end, half_end;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 par_ok;

  assign par_ok = ~(^{data_q, par_q});
`endif

  assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign half_end = (cnt_q == CW'(HALF - 1));

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      push_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      push_q  <= push_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Every state change clears the baud counter so the next sample lands mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    data_d    = data_q;
    push_d    = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    parity_err = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (half_end) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s;
          idx_d         = idx_q + IW'(1);
          if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            push_d     = par_ok;
            parity_err = ~par_ok;
`else
            push_d = 1'b1;
`endif
          end else begin
            frame_err = 1'b1;
            state_d   = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q, rptr_q;
  logic                 empty, full, pop, wr_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & rx_if.rx_ready;
  assign wr_en = push_q & (~full | pop);
  assign overrun = push_q & full & ~pop;

  always_ff @(posedge PCLK) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= data_q;
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)   rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  assign rx_if.rx_valid = ~empty;
  assign rx_if.rx_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
endmodule
